mips_btb_predictor: RTL and testbench

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the MIPS pipeline. It is looked up combinationally in IF with the current PC and supplies a predicted-taken flag and target to the next-PC mux. It is trained from ID, where the branch outcome and target are resolved. Compared with the fixed-size, always-taken BTB it replaces, it adds configurable depth, per-entry direction hysteresis, tag checking, bulk invalidation and optional statistics.

---
 rtl/btb_pkg.sv | 17 +
 rtl/btb_sat_ctr.sv | 22 ++
 rtl/mips_btb_predictor.sv | 154 +++++++++++++++
 tb/tb_mips_btb_predictor.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared constants for the MIPS branch target buffer.
// Counter encoding and the reset / allocation counter states.
package btb_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam logic [1:0] CTR_RST   = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    function automatic logic ctr_taken(input logic [1:0] c);
        return c[1];
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating direction counter next-state function.
// Taken counts up towards ST, not-taken counts down towards SNT.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (1'b1)
            (taken_i && (ctr_i != CTR_ST)):
                ctr_o = ctr_i + 2'd1;
            (!taken_i && (ctr_i != CTR_SNT)):
                ctr_o = ctr_i - 2'd1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, looked up in IF, trained in ID.
// Optional update/mispredict counters are built when BTB_STATS_EN is defined.
module mips_btb_predictor
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[PC_W-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Lookup sees registered state only; a same-cycle update is not bypassed.
    assign pred_hit    = lk_hit;
    assign pred_taken  = lk_hit && ctr_taken(ctr_q[lk_idx]);
    assign pred_target = lk_hit ? tgt_q[lk_idx] : '0;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       ctr_nxt;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[PC_W-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    btb_sat_ctr u_sat_ctr (
        .ctr_i   (ctr_q[up_idx]),
        .taken_i (upd_taken),
        .ctr_o   (ctr_nxt)
    );

    logic       wr_ctr;
    logic       wr_tgt;
    logic       wr_alloc;
    logic [1:0] ctr_d;

    always_comb begin
        wr_ctr   = 1'b0;
        wr_tgt   = 1'b0;
        wr_alloc = 1'b0;
        ctr_d    = ctr_nxt;
        if (upd_en && !flush) begin
            if (up_hit) begin
                wr_ctr = 1'b1;
                wr_tgt = upd_taken;
            end else if (upd_taken) begin
                wr_alloc = 1'b1;
                wr_ctr   = 1'b1;
                wr_tgt   = 1'b1;
                ctr_d    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_RST;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (wr_alloc) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
            end
            if (wr_ctr) begin
                ctr_q[up_idx] <= ctr_d;
            end
            if (wr_tgt) begin
                tgt_q[up_idx] <= upd_target;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic        up_pred;
    logic        up_mis;
    logic [31:0] look_q;
    logic [31:0] look_d;
    logic [31:0] mis_q;
    logic [31:0] mis_d;

    // A correct direction can still mispredict when the target moved.
    assign up_pred = up_hit && ctr_taken(ctr_q[up_idx]);
    assign up_mis  = (up_pred != upd_taken)
                   || (up_pred && upd_taken
                       && (tgt_q[up_idx] != upd_target));

    always_comb begin
        look_d = look_q;
        mis_d  = mis_q;
        if (upd_en && !flush) begin
            look_d = look_q + 32'd1;
            if (up_mis) begin
                mis_d = mis_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            look_q <= '0;
            mis_q  <= '0;
        end else begin
            look_q <= look_d;
            mis_q  <= mis_d;
        end
    end

    assign stat_lookups     = look_q;
    assign stat_mispredicts = mis_q;
`endif

    logic unused_lsbs;
    assign unused_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_mips_btb_predictor.sv
// Randomised and directed bench for mips_btb_predictor against a table model.
// Define BTB_STATS_EN to also check the statistics counters.
module tb_mips_btb_predictor;

    localparam int ENTRIES = 16;
    localparam int PC_W    = 32;
    localparam int IDX_W   = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    always #5 CLK = ~CLK;

    mips_btb_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .if_pc       (if_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural table: one slot per index, counter kept as a plain integer.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_look;
    int unsigned m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    function automatic logic [33:0] m_lookup(input logic [31:0] pc);
        int  i;
        bit  h;
        i = idx_of(pc);
        h = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (!h) return 34'h0;
        return {1'b1, (m_ctr[i] >= 2), m_tgt[i]};
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_look = 0;
        m_mis  = 0;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit taken,
                                     input logic [31:0] tgt);
        int i;
        bit h;
        bit pt;
        i  = idx_of(pc);
        h  = m_valid[i] && (m_tag[i] == tag_of(pc));
        pt = h && (m_ctr[i] >= 2);
        m_look++;
        if ((pt != taken) || (pt && taken && (m_tgt[i] != tgt))) m_mis++;
        if (h) begin
            if (taken) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_tgt[i] = tgt;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (taken) begin
            m_valid[i] = 1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endfunction

    task automatic do_reset();
        RESET      = 1'b1;
        upd_en     = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        flush      = 1'b0;
        if_pc      = '0;
        m_reset();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic do_upd(input bit en, input logic [31:0] pc, input bit taken,
                          input logic [31:0] tgt, input bit fl);
        @(negedge CLK);
        upd_en     = en;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        flush      = fl;
        @(posedge CLK);
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
        end else if (en) begin
            m_update(pc, taken, tgt);
        end
        #1;
        upd_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3];
        do_reset();
        pcs[0] = 32'h0040_0010;
        pcs[1] = 32'h0000_0000;
        pcs[2] = 32'hffff_fffc;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if_pc = pcs[k];
            #1;
            n_checks++;
            if ({pred_hit, pred_taken, pred_target} !== 34'h0) begin
                n_fail++;
                $display("FAIL reset_lookup pc=%h got hit=%b tk=%b tgt=%h want 0/0/0",
                         pcs[k], pred_hit, pred_taken, pred_target);
            end
        end
`ifdef BTB_STATS_EN
        n_checks++;
        if ({stat_lookups, stat_mispredicts} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_stats got %0d/%0d want 0/0",
                     stat_lookups, stat_mispredicts);
        end
`endif
    endtask

    task automatic test_alloc();
        do_upd(1, 32'h0040_0010, 1, 32'h0040_0100, 0);
        @(negedge CLK);
        if_pc = 32'h0040_0010;
        #1;
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h0040_0100}) begin
            n_fail++;
            $display("FAIL alloc got hit=%b tk=%b tgt=%h want 1/1/00400100",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_hysteresis();
        bit exp_tk [4];
        bit dir    [4];
        dir[0] = 0; exp_tk[0] = 0;
        dir[1] = 0; exp_tk[1] = 0;
        dir[2] = 1; exp_tk[2] = 0;
        dir[3] = 1; exp_tk[3] = 1;
        for (int k = 0; k < 4; k++) begin
            do_upd(1, 32'h0040_0010, dir[k], 32'h0040_0100, 0);
            @(negedge CLK);
            if_pc = 32'h0040_0010;
            #1;
            n_checks++;
            if ({pred_hit, pred_taken, pred_target}
                    !== {1'b1, exp_tk[k], 32'h0040_0100}) begin
                n_fail++;
                $display("FAIL hyst step%0d got hit=%b tk=%b tgt=%h want 1/%b/00400100",
                         k, pred_hit, pred_taken, pred_target, exp_tk[k]);
            end
        end
    endtask

    task automatic test_alias();
        @(negedge CLK);
        if_pc = 32'h0040_0410;
        #1;
        n_checks++;
        if (pred_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_probe got hit=%b want 0", pred_hit);
        end
        do_upd(1, 32'h0040_0410, 1, 32'h0040_0800, 0);
        @(negedge CLK);
        if_pc = 32'h0040_0010;
        #1;
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== 34'h0) begin
            n_fail++;
            $display("FAIL alias_evict got hit=%b tk=%b tgt=%h want 0/0/0",
                     pred_hit, pred_taken, pred_target);
        end
        if_pc = 32'h0040_0410;
        #1;
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h0040_0800}) begin
            n_fail++;
            $display("FAIL alias_new got hit=%b tk=%b tgt=%h want 1/1/00400800",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_flush();
        logic [31:0] pcs [3];
`ifdef BTB_STATS_EN
        logic [31:0] l0;
`endif
        do_upd(1, 32'h0040_0020, 1, 32'h0040_0200, 0);
`ifdef BTB_STATS_EN
        l0 = stat_lookups;
`endif
        do_upd(1, 32'h0040_0a40, 1, 32'h0040_0300, 1);
        pcs[0] = 32'h0040_0410;
        pcs[1] = 32'h0040_0020;
        pcs[2] = 32'h0040_0a40;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if_pc = pcs[k];
            #1;
            n_checks++;
            if (pred_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL flush pc=%h got hit=%b want 0", pcs[k], pred_hit);
            end
        end
`ifdef BTB_STATS_EN
        n_checks++;
        if (stat_lookups !== l0) begin
            n_fail++;
            $display("FAIL flush_stats got %0d want %0d", stat_lookups, l0);
        end
`endif
    endtask

`ifdef BTB_STATS_EN
    task automatic test_stats();
        logic [31:0] l0;
        logic [31:0] m0;
        do_upd(1, 32'h0040_0100, 1, 32'h0040_1000, 0);
        do_upd(1, 32'h0040_0204, 1, 32'h0040_2000, 0);
        l0 = stat_lookups;
        m0 = stat_mispredicts;
        do_upd(1, 32'h0040_0100, 1, 32'h0040_1000, 0);
        do_upd(1, 32'h0040_0204, 0, 32'h0040_2000, 0);
        do_upd(1, 32'h0040_0100, 1, 32'h0040_1040, 0);
        n_checks++;
        if ((stat_lookups - l0) !== 32'd3 || (stat_mispredicts - m0) !== 32'd2) begin
            n_fail++;
            $display("FAIL stats_delta got %0d/%0d want 3/2",
                     stat_lookups - l0, stat_mispredicts - m0);
        end
        // Reset lands between edges while an update is pending.
        @(negedge CLK);
        if_pc      = 32'h0040_0100;
        upd_en     = 1'b1;
        upd_pc     = 32'h0040_0300;
        upd_taken  = 1'b1;
        upd_target = 32'h0040_3000;
        @(posedge CLK);
        m_update(32'h0040_0300, 1, 32'h0040_3000);
        #3;
        RESET = 1'b1;
        m_reset();
        #1;
        n_checks++;
        if ({stat_lookups, stat_mispredicts} !== 64'h0 || pred_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got %0d/%0d hit=%b want 0/0 hit=0",
                     stat_lookups, stat_mispredicts, pred_hit);
        end
        @(negedge CLK);
        upd_en = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] lpc;
        logic [31:0] tgt;
        logic [33:0] exp;
        bit          fl;
        bit          en;
        bit          tk;
        int          errs;
        pool[0] = 32'h0040_0010;
        pool[1] = 32'h0040_0410;
        pool[2] = 32'h0040_0020;
        pool[3] = 32'h0040_0824;
        pool[4] = 32'h0040_1030;
        pool[5] = 32'h0040_003c;
        pool[6] = 32'h1000_0010;
        pool[7] = 32'h0040_043c;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            fl         = ($urandom_range(0, 29) == 0);
            en         = ($urandom_range(0, 3) != 0);
            tk         = $urandom_range(0, 1);
            tgt        = 32'h0040_4000 + 32'($urandom_range(0, 3) << 4);
            upd_en     = en;
            upd_pc     = pool[$urandom_range(0, 7)];
            upd_taken  = tk;
            upd_target = tgt;
            flush      = fl;
            lpc        = $urandom_range(0, 1) ? upd_pc : pool[$urandom_range(0, 7)];
            if_pc      = lpc;
            #1;
            exp = m_lookup(lpc);
            n_checks++;
            if ({pred_hit, pred_taken, pred_target} !== exp) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL rand_lookup n=%0d pc=%h got %b/%b/%h want %b/%b/%h",
                             n, lpc, pred_hit, pred_taken, pred_target,
                             exp[33], exp[32], exp[31:0]);
                errs++;
            end
            @(posedge CLK);
            if (fl) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            end else if (en) begin
                m_update(upd_pc, tk, tgt);
            end
            #1;
            upd_en = 1'b0;
            flush  = 1'b0;
        end
`ifdef BTB_STATS_EN
        n_checks++;
        if (stat_lookups !== m_look || stat_mispredicts !== m_mis) begin
            n_fail++;
            $display("FAIL rand_stats got %0d/%0d want %0d/%0d",
                     stat_lookups, stat_mispredicts, m_look, m_mis);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_hysteresis();
        test_alias();
        test_flush();
`ifdef BTB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
